// File: rtl/mem_access_unit.sv
// Memory-stage access unit: store/load alignment, a store buffer drained over a
// req/ack bus, loads ordered behind buffered stores, and misalignment flags.
module mem_access_unit #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int SB_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_sext,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [31:0]           req_pc,
    output logic                  stall,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rvalid,
    output logic                  exc_adel,
    output logic                  exc_ades,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W/8-1:0]   bus_be,
    output logic [DATA_W-1:0]     bus_wdata,
    output logic [31:0]           bus_pc,
    input  logic                  bus_ack,
    input  logic [DATA_W-1:0]     bus_rdata
);
    localparam int LANES = DATA_W / 8;
    localparam int LB    = $clog2(LANES);
    localparam int PW    = $clog2(SB_DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0] sb_addr  [SB_DEPTH];
    logic [LANES-1:0]  sb_be    [SB_DEPTH];
    logic [DATA_W-1:0] sb_wdata [SB_DEPTH];
    logic [31:0]       sb_pc    [SB_DEPTH];
    logic [PW-1:0]     head, tail;
    logic [PW:0]       count;

    logic [LB-1:0]     lane;
    logic [3:0]        nbytes;
    int                lane_i, nbits;
    logic              misaligned, sb_full, push, pop;
    logic [LANES-1:0]  be;
    logic [DATA_W-1:0] wmask, wdata, rshift, ld_ext;
    logic [ADDR_W-1:0] line_addr;

    always_comb begin
        lane       = req_addr[LB-1:0];
        nbytes     = 4'd1 << req_size;
        lane_i     = int'(lane);
        nbits      = (8 * int'(nbytes) > DATA_W) ? DATA_W : 8 * int'(nbytes);
        misaligned = ((lane & LB'(nbytes - 4'd1)) != '0) || (req_size == 2'b11 && DATA_W == 32);
        line_addr  = {req_addr[ADDR_W-1:LB], LB'(0)};
        for (int i = 0; i < LANES; i++)
            be[i] = (i >= lane_i) && (i < lane_i + int'(nbytes));
        for (int i = 0; i < DATA_W; i++)
            wmask[i] = (i < nbits);
        wdata  = (req_wdata & wmask) << (8 * lane_i);
        // Load data is taken straight from the held request: it cannot change while stalled.
        rshift = bus_rdata >> (8 * lane_i);
        for (int i = 0; i < DATA_W; i++)
            ld_ext[i] = (i < nbits) ? rshift[i] : (req_sext & rshift[nbits-1]);
    end

    assign sb_full  = (count == (PW+1)'(SB_DEPTH));
    assign exc_adel = req_valid & ~req_we & misaligned;
    assign exc_ades = req_valid &  req_we & misaligned;
    assign push     = reset & req_valid & req_we & ~misaligned & ~sb_full;
    assign stall    = reset & req_valid & ~misaligned & (req_we ? sb_full : (state != RESP));
    assign rvalid   = reset & (state == RESP);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE:  if (count != '0)                               state_nxt = WRITE;
                   else if (req_valid && !req_we && !misaligned)  state_nxt = READ;
            WRITE: if (bus_ack) begin pop = 1'b1; state_nxt = IDLE; end
            READ:  if (bus_ack) state_nxt = RESP;
            RESP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                sb_addr[tail]  <= line_addr;
                sb_be[tail]    <= be;
                sb_wdata[tail] <= wdata;
                sb_pc[tail]    <= req_pc;
                tail           <= tail + 1'b1;
            end
            if (pop) head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Bus outputs load on entry to a transaction, so they hold steady until ack.
    always_ff @(posedge clk) begin
        if (!reset || (state_nxt != WRITE && state_nxt != READ)) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            bus_pc    <= '0;
        end else if (state_nxt == WRITE) begin
            bus_req   <= 1'b1;
            bus_we    <= 1'b1;
            bus_addr  <= sb_addr[head];
            bus_be    <= sb_be[head];
            bus_wdata <= sb_wdata[head];
            bus_pc    <= sb_pc[head];
        end else begin
            bus_req   <= 1'b1;
            bus_we    <= 1'b0;
            bus_addr  <= line_addr;
            bus_be    <= '0;
            bus_wdata <= '0;
            bus_pc    <= req_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)                       rdata <= '0;
        else if (state == READ && bus_ack) rdata <= ld_ext;
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a 32-bit instance for most scenarios and
// a 64-bit instance for doubleword alignment and extension.
module tb_mem_access_unit;
    logic        clk = 0;
    logic        reset, req_valid, req_we, req_sext, bus_ack;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, req_pc, bus_rdata;
    logic        stall, rvalid, exc_adel, exc_ades, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata, bus_pc;
    logic [3:0]  bus_be;

    logic        w_reset, w_req_valid, w_req_we, w_req_sext, w_bus_ack;
    logic [1:0]  w_req_size;
    logic [31:0] w_req_addr, w_req_pc, w_bus_addr, w_bus_pc;
    logic [63:0] w_req_wdata, w_bus_rdata, w_rdata, w_bus_wdata;
    logic        w_stall, w_rvalid, w_exc_adel, w_exc_ades, w_bus_req, w_bus_we;
    logic [7:0]  w_bus_be;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] pc;
    } wr_t;
    wr_t         wq[$];
    logic [31:0] lq[$];
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .SB_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_sext(req_sext), .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
        .stall(stall), .rdata(rdata), .rvalid(rvalid), .exc_adel(exc_adel), .exc_ades(exc_ades),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_pc(bus_pc), .bus_ack(bus_ack), .bus_rdata(bus_rdata));

    mem_access_unit #(.DATA_W(64), .ADDR_W(32), .SB_DEPTH(4)) dut64 (
        .clk(clk), .reset(w_reset), .req_valid(w_req_valid), .req_we(w_req_we), .req_size(w_req_size),
        .req_sext(w_req_sext), .req_addr(w_req_addr), .req_wdata(w_req_wdata), .req_pc(w_req_pc),
        .stall(w_stall), .rdata(w_rdata), .rvalid(w_rvalid), .exc_adel(w_exc_adel), .exc_ades(w_exc_ades),
        .bus_req(w_bus_req), .bus_we(w_bus_we), .bus_addr(w_bus_addr), .bus_be(w_bus_be),
        .bus_wdata(w_bus_wdata), .bus_pc(w_bus_pc), .bus_ack(w_bus_ack), .bus_rdata(w_bus_rdata));

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic we, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] pc);
        req_valid = 1; req_we = we; req_size = sz; req_sext = sx;
        req_addr = a; req_wdata = d; req_pc = pc;
    endtask

    task automatic test_reset;
        reset = 0; w_reset = 0; bus_ack = 0; w_bus_ack = 0; bus_rdata = 0; w_bus_rdata = 0;
        drive(1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 32'h40);
        w_req_valid = 1; w_req_we = 1; w_req_size = 2'b11; w_req_sext = 0;
        w_req_addr = 32'h0; w_req_wdata = 64'h1; w_req_pc = 32'h0;
        tick; tick;
        tests++; if ({stall, rvalid, bus_req, bus_we} !== 4'b0)
            begin fails++; $display("FAIL reset_ctl: got %b expected 0000", {stall, rvalid, bus_req, bus_we}); end
        tests++; if ({bus_addr, bus_be, bus_wdata, bus_pc, rdata} !== '0)
            begin fails++; $display("FAIL reset_data: got %h/%h/%h/%h/%h expected 0", bus_addr, bus_be, bus_wdata, bus_pc, rdata); end
        tests++; if ({w_stall, w_bus_req, w_bus_be, w_rdata} !== '0)
            begin fails++; $display("FAIL reset_64: got %b/%b/%h/%h expected 0", w_stall, w_bus_req, w_bus_be, w_rdata); end
        reset = 1; w_reset = 1; req_valid = 0; w_req_valid = 0;
        tick; tick; tick;
        tests++; if (bus_req !== 1'b0)
            begin fails++; $display("FAIL reset_sb_empty: bus_req got %b expected 0", bus_req); end
    endtask

    task automatic check_write(input string name);
        wr_t e;
        e = wq.pop_front();
        tests++; if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== e.addr || bus_be !== e.be ||
                     bus_wdata !== e.wdata || bus_pc !== e.pc)
            begin fails++; $display("FAIL %s: got req=%b we=%b a=%h be=%b d=%h pc=%h expected a=%h be=%b d=%h pc=%h",
                                    name, bus_req, bus_we, bus_addr, bus_be, bus_wdata, bus_pc, e.addr, e.be, e.wdata, e.pc); end
    endtask

    task automatic test_store;
        drive(1, 2'b00, 0, 32'h1003, 32'h000000AB, 32'h400); #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL sb_stall: got %b expected 0", stall); end
        wq.push_back('{32'h1000, 4'b1000, 32'hAB000000, 32'h400});
        tick; req_valid = 0;
        tests++; if (bus_req !== 1'b0) begin fails++; $display("FAIL sb_req_n1: got %b expected 0", bus_req); end
        tick;
        check_write("sb_bus");
        bus_ack = 1; tick; bus_ack = 0;
        tests++; if (bus_req !== 1'b0) begin fails++; $display("FAIL sb_req_drop: got %b expected 0", bus_req); end

        drive(1, 2'b01, 0, 32'h1002, 32'hFFFF1234, 32'h404);
        wq.push_back('{32'h1000, 4'b1100, 32'h12340000, 32'h404});
        tick; req_valid = 0;
        tests++; if (bus_req !== 1'b0) begin fails++; $display("FAIL sh_req_n1: got %b expected 0", bus_req); end
        tick;
        check_write("sh_bus");
        bus_ack = 1; tick; bus_ack = 0; tick;
    endtask

    task automatic test_loads;
        logic [1:0]  sz  [6] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00};
        logic        sx  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] off [6] = '{32'd1, 32'd2, 32'd2, 32'd0, 32'd3, 32'd3};
        logic [31:0] exp [6] = '{32'h0000007F, 32'hFFFF80FF, 32'h000080FF, 32'h80FF7F01, 32'hFFFFFF80, 32'h00000080};
        logic [31:0] e;
        bus_rdata = 32'h80FF7F01;
        for (int i = 0; i < 6; i++) begin
            drive(0, sz[i], sx[i], 32'h2000 + off[i], 32'h0, 32'h800 + 4 * i); #1;
            lq.push_back(exp[i]);
            tests++; if (stall !== 1'b1) begin fails++; $display("FAIL ld%0d_stall: got %b expected 1", i, stall); end
            bus_ack = 1; tick;
            tests++; if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_be !== 4'b0 || bus_addr !== 32'h2000)
                begin fails++; $display("FAIL ld%0d_bus: got req=%b we=%b be=%b a=%h expected 1 0 0000 00002000", i, bus_req, bus_we, bus_be, bus_addr); end
            tick;
            e = lq.pop_front();
            tests++; if (rvalid !== 1'b1 || stall !== 1'b0 || rdata !== e)
                begin fails++; $display("FAIL ld%0d_data: got rv=%b st=%b d=%h expected 1 0 %h", i, rvalid, stall, rdata, e); end
            req_valid = 0; bus_ack = 0; tick;
            tests++; if (rvalid !== 1'b0) begin fails++; $display("FAIL ld%0d_pulse: got %b expected 0", i, rvalid); end
        end
    endtask

    task automatic test_back_to_back;
        int nw = 0; bit done = 0, seen_read = 0;
        logic [31:0] e;
        bus_ack = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 2'b10, 0, 32'h3000 + 4 * i, 32'h10000000 + i, 32'h500 + 4 * i); #1;
            tests++; if (stall !== 1'b0) begin fails++; $display("FAIL fill%0d_stall: got %b expected 0", i, stall); end
            wq.push_back('{32'h3000 + 4 * i, 4'hF, 32'h10000000 + i, 32'h500 + 4 * i});
            tick;
        end
        drive(1, 2'b10, 0, 32'h3010, 32'h10000004, 32'h510); #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL full_stall: got %b expected 1", stall); end
        check_write("full_head");
        bus_ack = 1; tick;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL after_pop_stall: got %b expected 0", stall); end
        wq.push_back('{32'h3010, 4'hF, 32'h10000004, 32'h510});
        tick;
        drive(0, 2'b10, 0, 32'h3000, 32'h0, 32'h520);
        bus_rdata = 32'hCAFEF00D; lq.push_back(32'hCAFEF00D); #1;
        for (int c = 0; c < 60 && !done; c++) begin
            if (bus_req && bus_we) begin
                nw++;
                if (wq.size() > 0) check_write("drain");
            end else if (bus_req && !bus_we && !seen_read) begin
                seen_read = 1;
                tests++; if (wq.size() != 0) begin fails++; $display("FAIL order: read with %0d writes left, expected 0", wq.size()); end
            end
            if (rvalid) begin
                e = lq.pop_front(); done = 1;
                tests++; if (rdata !== e) begin fails++; $display("FAIL b2b_load: got %h expected %h", rdata, e); end
            end
            if (!done) tick;
        end
        if (!done) begin tests++; fails++; $display("FAIL b2b_timeout: got no rvalid expected one within 60 cycles"); end
        tests++; if (nw != 4) begin fails++; $display("FAIL drain_count: got %0d expected 4", nw); end
        req_valid = 0; bus_ack = 0; tick;
    endtask

    task automatic test_misaligned;
        drive(0, 2'b10, 0, 32'h1002, 32'h0, 32'h600); #1;
        tests++; if (exc_adel !== 1'b1 || exc_ades !== 1'b0 || stall !== 1'b0)
            begin fails++; $display("FAIL lw_mis: got adel=%b ades=%b stall=%b expected 1 0 0", exc_adel, exc_ades, stall); end
        tick; tick;
        tests++; if (bus_req !== 1'b0) begin fails++; $display("FAIL lw_mis_bus: got %b expected 0", bus_req); end
        drive(1, 2'b11, 0, 32'h1000, 32'h55, 32'h604); #1;
        tests++; if (exc_ades !== 1'b1 || exc_adel !== 1'b0 || stall !== 1'b0)
            begin fails++; $display("FAIL sd32_mis: got ades=%b adel=%b stall=%b expected 1 0 0", exc_ades, exc_adel, stall); end
        tick;
        drive(1, 2'b01, 0, 32'h1001, 32'h55, 32'h608); #1;
        tests++; if (exc_ades !== 1'b1) begin fails++; $display("FAIL sh_mis: got %b expected 1", exc_ades); end
        tick; req_valid = 0; tick; tick;
        tests++; if (bus_req !== 1'b0) begin fails++; $display("FAIL st_mis_bus: got %b expected 0", bus_req); end
    endtask

    task automatic test_reset_mid_read;
        bit pulsed = 0;
        bus_ack = 0;
        drive(0, 2'b10, 0, 32'h4000, 32'h0, 32'h700); tick;
        tests++; if (bus_req !== 1'b1) begin fails++; $display("FAIL rmr_req: got %b expected 1", bus_req); end
        reset = 0; tick; req_valid = 0;
        tests++; if (bus_req !== 1'b0 || rvalid !== 1'b0)
            begin fails++; $display("FAIL rmr_drop: got req=%b rv=%b expected 0 0", bus_req, rvalid); end
        reset = 1; bus_ack = 1;
        for (int c = 0; c < 6; c++) begin tick; if (rvalid) pulsed = 1; end
        tests++; if (pulsed) begin fails++; $display("FAIL rmr_rvalid: got pulse expected none"); end
        bus_ack = 0;
    endtask

    task automatic test_dword;
        w_req_valid = 1; w_req_we = 1; w_req_size = 2'b11; w_req_sext = 0;
        w_req_addr = 32'h8; w_req_wdata = 64'h1122334455667788; w_req_pc = 32'h900; #1;
        tests++; if (w_stall !== 1'b0) begin fails++; $display("FAIL sd_stall: got %b expected 0", w_stall); end
        tick; w_req_valid = 0; tick;
        tests++; if (w_bus_req !== 1'b1 || w_bus_be !== 8'hFF || w_bus_addr !== 32'h8 || w_bus_wdata !== 64'h1122334455667788)
            begin fails++; $display("FAIL sd_bus: got req=%b be=%h a=%h d=%h expected 1 ff 8 1122334455667788", w_bus_req, w_bus_be, w_bus_addr, w_bus_wdata); end
        w_bus_ack = 1; tick; w_bus_ack = 0; tick;
        w_req_valid = 1; w_req_we = 1; w_req_size = 2'b10; w_req_addr = 32'h1C; w_req_wdata = 64'hAABBCCDD; tick;
        w_req_valid = 0; tick;
        tests++; if (w_bus_be !== 8'hF0 || w_bus_addr !== 32'h18 || w_bus_wdata !== 64'hAABBCCDD00000000)
            begin fails++; $display("FAIL sw64_bus: got be=%h a=%h d=%h expected f0 18 aabbccdd00000000", w_bus_be, w_bus_addr, w_bus_wdata); end
        w_bus_ack = 1; tick; w_bus_ack = 0; tick;
        w_bus_rdata = 64'h8000000100000000;
        w_req_valid = 1; w_req_we = 0; w_req_size = 2'b10; w_req_sext = 1; w_req_addr = 32'hC; w_bus_ack = 1;
        tick; tick;
        tests++; if (w_rvalid !== 1'b1 || w_rdata !== 64'hFFFFFFFF80000001)
            begin fails++; $display("FAIL lw64_sext: got rv=%b d=%h expected 1 ffffffff80000001", w_rvalid, w_rdata); end
        w_req_valid = 0; w_bus_ack = 0; tick;
        w_req_valid = 1; w_req_we = 1; w_req_size = 2'b11; w_req_addr = 32'h4; #1;
        tests++; if (w_exc_ades !== 1'b1 || w_stall !== 1'b0)
            begin fails++; $display("FAIL sd_mis: got ades=%b stall=%b expected 1 0", w_exc_ades, w_stall); end
        w_req_valid = 0; tick;
    endtask

    initial begin
        test_reset;
        test_store;
        test_loads;
        test_back_to_back;
        test_misaligned;
        test_reset_mid_read;
        test_dword;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised memory-stage access unit for the pipelined MIPS core, sitting between the M stage and the external data bus. It aligns store data and generates byte enables for byte, half, word and (at 64-bit width) doubleword accesses. It extracts and sign- or zero-extends load data. Unlike a purely combinational port, it buffers stores in a FIFO and drains them over a req/ack bus handshake, orders loads behind buffered stores, stalls the pipeline, and flags misaligned addresses.

## Interface
- DATA_W, 32: bus and data width; 32 or 64. LANES = DATA_W/8, LB = log2(LANES).
- ADDR_W, 32: address width.
- SB_DEPTH, 4: store-buffer entries; power of two, ≥2.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- req_valid  in  1  M-stage access present this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 dword (legal only when DATA_W=64).
- req_sext  in  1  loads: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- req_pc  in  32  PC of the access instruction.
- stall  out  1  freeze pipeline; request inputs are held stable while 1.
- rdata  out  DATA_W  extended load result; valid when rvalid=1.
- rvalid  out  1  one-cycle pulse when a load completes.
- exc_adel / exc_ades  out  1  misaligned load / store, combinational with request.
- bus_req  out  1  bus transaction request; held until bus_ack.
- bus_we  out  1  transaction is a write.
- bus_addr  out  ADDR_W  req_addr with low LB bits forced to 0.
- bus_be  out  LANES  byte enables (writes); all zero for reads.
- bus_wdata  out  DATA_W  lane-aligned write data.
- bus_pc  out  32  PC of the instruction owning the transaction.
- bus_ack  in  1  completes the current transaction; may arrive in the same cycle bus_req rises.
- bus_rdata  in  DATA_W  read data, sampled on the read's ack cycle.

## Operation
- Misaligned: half with addr[0]≠0, word with addr[1:0]≠0, dword with addr[2:0]≠0, or size 11 at DATA_W=32. The matching exc_* = req_valid & misaligned. No enqueue, no bus traffic, and stall=0.
- Lane: lane = addr[LB-1:0]. be = ((1<<bytes)−1) << lane. wdata = req_wdata << (8·lane), with unused bits 0.
- Store accept: an aligned store with SB count < SB_DEPTH is enqueued as {bus_addr, be, wdata, pc}, with stall=0 that cycle. When the SB is full, stall=1. A pop in the same cycle does not bypass: the store is accepted the following cycle.
- Load: an aligned load raises stall=1 and stays pending. It is issued only when the SB is empty, so all earlier stores reach the bus first.
- Bus FSM states are IDLE, WRITE, READ and RESP.
  - IDLE: if SB is non-empty, go to WRITE (head entry). Otherwise, if a load is pending, go to READ.
  - WRITE: bus_req=1, bus_we=1, bus_* = SB head. On bus_ack, pop and return to IDLE.
  - READ: bus_req=1, bus_we=0, bus_be=0. On bus_ack, register rdata = ext((bus_rdata >> 8·lane) masked to size) and go to RESP.
  - RESP: rvalid=1 and stall=0, so the pipeline consumes rdata. Next state is IDLE.
- bus_* are registered and stable from bus_req rise to bus_ack. They are 0 in IDLE and RESP.
- The SB is a circular buffer with head/tail pointers that wrap modulo SB_DEPTH. count ranges 0..SB_DEPTH. A simultaneous push and pop leaves count unchanged.

## Timing
- Reset (reset=0 at an edge) clears the SB (count=0, pointers=0) and sets state=IDLE. It also clears stall, rvalid, rdata, bus_req, bus_we, bus_addr, bus_be, bus_wdata and bus_pc to 0. An in-flight transaction is abandoned, bus_req=0 the next cycle, and buffered stores are discarded.
- Store accepted at cycle N: the entry is visible at N+1 and bus_req rises at N+2 if the FSM is idle.
- Load at cycle N, SB empty, ack immediate: READ at N+1, RESP (rvalid, stall=0) at N+2. That is 2 stall cycles, plus 1 per extra ack wait cycle.
- A load behind k buffered stores with immediate acks completes after all k writes. Each write costs 2 cycles (WRITE and IDLE).
- exc_* and the store-accept decision are same-cycle combinational. stall depends on count, state and request.

## Test plan
- Reset: hold reset=0 for 2 cycles with req_valid=1. All outputs must be 0 and count=0.
- Stores, DATA_W=32: sb 0xAB @0x1003 gives bus_be=1000, bus_wdata=0xAB000000, bus_addr=0x1000. sh 0x1234 @0x1002 gives be=1100, wdata=0x12340000, with bus_req 2 cycles after accept.
- Loads: with bus_rdata=0x80FF7F01, lb @+1 sext gives 0x0000007F, lh @+2 sext gives 0xFFFF80FF, and lhu @+2 gives 0x000080FF. Each has rvalid at N+2 with immediate ack.
- Ordering/full: with SB_DEPTH=4 and bus_ack held 0, five stores give stall=1 on the 5th. Release ack: the 5th is accepted the cycle after the first pop. A following load reads only after 5 writes complete.
- Misaligned: lw @0x1002 gives exc_adel=1, stall=0 and no bus_req. size=11 at DATA_W=32 gives exc_ades on a store.
- DATA_W=64 and reset mid-read: sd @0x8 sets be=0xFF. A reset during READ (ack=0) drops bus_req next cycle, and rvalid never pulses.
